// File: rtl/mux_pkg.sv
// Shared definitions for the N-way registered channel selector.
package mux_pkg;

    // Values of the external mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Mode FSM: remembers which mode the most recently accepted beat used.
    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } mode_state_e;

    // Number of bits needed to index 'value' items (value >= 2).
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way channel select with range detection.
// Out-of-range indices produce zero data rather than aliasing a real channel.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int N_IN   = 6,
    localparam int SEL_W  = clog2(N_IN)
) (
    input  logic [N_IN*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]       idx,
    output logic [DATA_W-1:0]      data_out,
    output logic                   in_range
);

    // Explicit compare per channel so no index can reach past the last channel.
    always_comb begin
        data_out = '0;
        in_range = (32'(idx) < N_IN);
        for (int i = 0; i < N_IN; i++) begin
            if (idx == SEL_W'(i)) begin
                data_out = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N-way selector with valid/ready on both sides.
// DIRECT mode picks the channel from sel; SCAN mode walks channels 0..N_IN-1,
// one per accepted beat. Out-of-range selects are flagged per beat (bad_sel)
// and latched in a sticky error flag (sel_err).
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Once out_valid rises, data_out/ch_out/bad_sel/
// scan_last stay stable until the consumer takes the beat with out_ready.
// in_ready = !out_valid || out_ready, so the single output register can be
// refilled in the same cycle it drains (1 beat per cycle).
module mux_sel_reg
    import mux_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int N_IN   = 6,
    localparam int SEL_W  = clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_IN*DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      data_out,
    output logic [SEL_W-1:0]       ch_out,
    output logic                   bad_sel,
    output logic                   scan_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   err_clr,
    output logic                   sel_err
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

    mode_state_e state_q, state_d;

    logic [SEL_W-1:0]  scan_idx_q, scan_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              bad_sel_q, bad_sel_d;
    logic              scan_last_q, scan_last_d;
    logic              sel_err_q, sel_err_d;

    logic              accept;
    logic              use_scan;
    logic [SEL_W-1:0]  scan_base;
    logic [SEL_W-1:0]  eff_idx;
    logic [DATA_W-1:0] mux_data;
    logic              mux_in_range;
    logic              set_err;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    mux_n_comb #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN)
    ) u_mux (
        .data_in  (data_in),
        .idx      (eff_idx),
        .data_out (mux_data),
        .in_range (mux_in_range)
    );

    // Mode FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DIRECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode FSM next state: follows the mode of each accepted beat.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    // Mode FSM outputs: effective index and scan counter update.
    // Entering SCAN from DIRECT restarts at channel 0.
    always_comb begin
        use_scan   = (mode == MODE_SCAN);
        scan_base  = (state_q == ST_SCAN) ? scan_idx_q : '0;
        eff_idx    = use_scan ? scan_base : sel;
        scan_idx_d = scan_idx_q;
        if (accept && use_scan) begin
            scan_idx_d = (scan_base == LAST_IDX) ? '0 : scan_base + SEL_W'(1);
        end
    end

    // Output stage and sticky error next values.
    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        ch_d        = ch_q;
        bad_sel_d   = bad_sel_q;
        scan_last_d = scan_last_q;
        sel_err_d   = sel_err_q;
        set_err     = accept && !use_scan && !mux_in_range;
        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = mux_data;
            ch_d        = eff_idx;
            bad_sel_d   = !mux_in_range;
            scan_last_d = use_scan && (eff_idx == LAST_IDX);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A set in the same cycle as a clear wins.
        if (set_err) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    // Datapath, scan counter and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_idx_q  <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ch_q        <= '0;
            bad_sel_q   <= 1'b0;
            scan_last_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            scan_idx_q  <= scan_idx_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            bad_sel_q   <= bad_sel_d;
            scan_last_q <= scan_last_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign ch_out    = ch_q;
    assign bad_sel   = bad_sel_q;
    assign scan_last = scan_last_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Directed bench for mux_sel_reg (DATA_W = 32, N_IN = 6, channel i = 'hA0 + i).
module tb_mux_sel_reg;

    localparam int DATA_W = 32;
    localparam int N_IN   = 6;
    localparam int SEL_W  = 3;
    localparam int EXP_W  = 2 + SEL_W + DATA_W;  // {bad_sel, scan_last, ch_out, data_out}

    logic                   clk;
    logic                   reset;
    logic [N_IN*DATA_W-1:0] data_in;
    logic [SEL_W-1:0]       sel;
    logic                   mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      data_out;
    logic [SEL_W-1:0]       ch_out;
    logic                   bad_sel;
    logic                   scan_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   err_clr;
    logic                   sel_err;

    mux_sel_reg #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .sel       (sel),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .bad_sel   (bad_sel),
        .scan_last (scan_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .sel_err   (sel_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    logic [EXP_W-1:0] exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic m_out_valid = 1'b0;
    logic m_sel_err   = 1'b0;
    logic m_in_scan   = 1'b0;
    int   m_scan_idx  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected beat for an accepted input, advancing the mode/scan model.
    task automatic model_accept(output logic [EXP_W-1:0] e, output logic set_err);
        int          idx;
        logic        bad;
        logic        last;
        logic [31:0] d;
        set_err = 1'b0;
        if (mode) begin
            idx        = m_in_scan ? m_scan_idx : 0;
            last       = (idx == N_IN - 1);
            bad        = 1'b0;
            d          = 32'hA0 + 32'(idx);
            m_scan_idx = last ? 0 : idx + 1;
            m_in_scan  = 1'b1;
        end else begin
            idx       = int'(sel);
            last      = 1'b0;
            bad       = (idx >= N_IN);
            d         = bad ? 32'h0 : 32'hA0 + 32'(idx);
            set_err   = bad;
            m_in_scan = 1'b0;
        end
        e = {bad, last, SEL_W'(idx), d};
    endtask

    // One clock: check registered outputs against the model, then advance.
    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic             acc;
        logic             set_err;
        logic [EXP_W-1:0] e;
        #1;
        check("in_ready", 64'(in_ready), 64'(!m_out_valid || out_ready));
        check("out_valid", 64'(out_valid), 64'(m_out_valid));
        check("sel_err", 64'(sel_err), 64'(m_sel_err));
        if (m_out_valid) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                check("beat", 64'({bad_sel, scan_last, ch_out, data_out}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        acc     = in_valid && (!m_out_valid || out_ready);
        set_err = 1'b0;
        if (acc) begin
            model_accept(e, set_err);
            exp_q.push_back(e);
        end
        if (!m_out_valid || out_ready) m_out_valid = acc;
        if (set_err) m_sel_err = 1'b1;
        else if (err_clr) m_sel_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 64'(data_out), 64'd0);
        check({tag, "_ch_out"}, 64'(ch_out), 64'd0);
        check({tag, "_bad_sel"}, 64'(bad_sel), 64'd0);
        check({tag, "_scan_last"}, 64'(scan_last), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_sel_err"}, 64'(sel_err), 64'd0);
    endtask

    // Reset asserted in the middle of a cycle; outputs must clear at once.
    task automatic mid_cycle_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        m_out_valid = 1'b0;
        m_sel_err   = 1'b0;
        m_in_scan   = 1'b0;
        m_scan_idx  = 0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        sel       = '0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        for (int i = 0; i < N_IN; i++) data_in[i*DATA_W +: DATA_W] = 32'hA0 + 32'(i);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        run(1);

        // DIRECT sel=3 single beat, then drain
        sel = 3'd3; in_valid = 1'b1;
        run(1);
        in_valid = 1'b0;
        run(2);

        // Out of range sel=6
        sel = 3'd6; in_valid = 1'b1;
        run(1);
        in_valid = 1'b0;
        run(1);
        // Clear coinciding with sel=7 accept: set wins
        sel = 3'd7; in_valid = 1'b1; err_clr = 1'b1;
        run(1);
        in_valid = 1'b0; err_clr = 1'b0;
        run(1);
        // Clear alone
        err_clr = 1'b1;
        run(1);
        err_clr = 1'b0;
        run(1);

        // SCAN: 8 beats back to back
        mode = 1'b1; in_valid = 1'b1; sel = 3'd5;
        run(8);
        in_valid = 1'b0;
        run(2);

        // Backpressure in SCAN with random sel (ignored in SCAN)
        in_valid = 1'b1;
        run(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 3'($urandom_range(0, 7));
            step();
        end
        out_ready = 1'b1;
        run(4);
        in_valid = 1'b0;
        run(2);

        // Mode switch mid-scan: fresh SCAN entry, four beats leaves scan_idx at 4
        mode = 1'b0; sel = 3'd0; in_valid = 1'b1;
        run(1);
        mode = 1'b1;
        run(4);
        mode = 1'b0; sel = 3'd2;
        run(1);
        mode = 1'b1;
        run(2);
        in_valid = 1'b0;
        run(1);

        // Reset during SCAN with a beat pending
        in_valid = 1'b1;
        run(3);
        mid_cycle_reset("reset_mid_scan");
        run(2);
        in_valid = 1'b0;
        run(2);

        // Randomised DIRECT beats with random backpressure
        mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            err_clr   = ($urandom_range(0, 3) == 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        run(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
